// File: rtl/sm_ramp_ctrl_if.sv
// Command and driver-side signal bundle for the stepper ramp sequencer.
// The slave side is the sequencer; the master side is the command layer.
interface sm_ramp_ctrl_if #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 32
);
  logic             cmd_start;
  logic             cmd_stop;
  logic [CNT_W-1:0] target_steps;
  logic             dir_in;
  logic [SIZE-1:0]  period_start;
  logic [SIZE-1:0]  period_min;
  logic [SIZE-1:0]  ramp_dec;
  logic             drv_step;
  logic             drv_dir;
  logic             drv_enable_SM;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] step_cnt;
  logic [SIZE-1:0]  cur_period;

  modport slave (
    input  cmd_start, cmd_stop, target_steps, dir_in,
    input  period_start, period_min, ramp_dec,
    output drv_step, drv_dir, drv_enable_SM, busy, done,
    output step_cnt, cur_period
  );

  modport master (
    output cmd_start, cmd_stop, target_steps, dir_in,
    output period_start, period_min, ramp_dec,
    input  drv_step, drv_dir, drv_enable_SM, busy, done,
    input  step_cnt, cur_period
  );
endinterface

// File: rtl/sm_ramp_ctrl.sv
// Trapezoidal stepper move sequencer: accelerate, cruise, decelerate,
// generating the step pulse train one period per step.
module sm_ramp_ctrl #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 32
) (
  input logic           clk,
  input logic           rst,
  sm_ramp_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ACCEL, CRUISE, DECEL, DONE
  } state_t;

  localparam logic [SIZE-1:0] P_FLOOR = SIZE'(4);

  state_t           state, state_nx;
  logic [SIZE-1:0]  ph, ph_nx;
  logic [SIZE-1:0]  p, p_nx;
  logic [SIZE-1:0]  ps_r, ps_nx;
  logic [SIZE-1:0]  pm_r, pm_nx;
  logic [SIZE-1:0]  dec_r, dec_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic [CNT_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             dir_r, dir_nx;
  logic             stop_req, stop_nx;

  logic [SIZE-1:0]  pm_c, ps_c;
  logic [SIZE:0]    sub, add;
  logic [SIZE-1:0]  p_dn, p_up;
  logic [CNT_W-1:0] rem_dec, rem_stop;
  logic             moving, step_end;

  assign pm_c = (bus.period_min > P_FLOOR) ? bus.period_min : P_FLOOR;
  assign ps_c = (bus.period_start > pm_c) ? bus.period_start : pm_c;

  // Borrow out of the subtract means the ramp overshot the cruise period.
  assign sub  = {1'b0, p} - {1'b0, dec_r};
  assign p_dn = (sub[SIZE] || (sub[SIZE-1:0] < pm_r)) ? pm_r : sub[SIZE-1:0];
  assign add  = {1'b0, p} + {1'b0, dec_r};
  assign p_up = (add > {1'b0, ps_r}) ? ps_r : add[SIZE-1:0];

  assign rem_dec  = rem - CNT_W'(1);
  assign rem_stop = (rem_dec < acc) ? rem_dec : acc;

  assign moving   = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
  assign step_end = (ph == p - SIZE'(1));

  assign bus.busy          = moving;
  assign bus.drv_enable_SM = moving;
  assign bus.done          = (state == DONE);
  assign bus.drv_step      = moving && (ph < (p >> 2));
  assign bus.drv_dir       = dir_r;
  assign bus.step_cnt      = cnt;
  assign bus.cur_period    = p;

  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    p_nx     = p;
    ps_nx    = ps_r;
    pm_nx    = pm_r;
    dec_nx   = dec_r;
    rem_nx   = rem;
    acc_nx   = acc;
    cnt_nx   = cnt;
    dir_nx   = dir_r;
    stop_nx  = stop_req;
    unique case (state)
      IDLE: begin
        if (bus.cmd_start) begin
          ps_nx   = ps_c;
          pm_nx   = pm_c;
          dec_nx  = bus.ramp_dec;
          dir_nx  = bus.dir_in;
          p_nx    = ps_c;
          rem_nx  = bus.target_steps;
          acc_nx  = '0;
          cnt_nx  = '0;
          ph_nx   = '0;
          stop_nx = 1'b0;
          if (bus.target_steps == '0)
            state_nx = DONE;
          else if ((ps_c > pm_c) && (bus.ramp_dec != '0))
            state_nx = ACCEL;
          else
            state_nx = CRUISE;
        end
      end
      ACCEL, CRUISE, DECEL: begin
        if (bus.cmd_stop)
          stop_nx = 1'b1;
        if (!step_end) begin
          ph_nx = ph + SIZE'(1);
        end else begin
          ph_nx  = '0;
          cnt_nx = cnt + CNT_W'(1);
          rem_nx = rem_dec;
          if (rem_dec == '0) begin
            state_nx = DONE;
            stop_nx  = 1'b0;
          end else if (stop_req) begin
            stop_nx = 1'b0;
            rem_nx  = rem_stop;
            if (rem_stop == '0) begin
              state_nx = DONE;
            end else begin
              state_nx = DECEL;
              p_nx     = p_up;
            end
          end else if ((state != DECEL) && (rem_dec <= acc)) begin
            state_nx = DECEL;
            p_nx     = p_up;
          end else if (state == DECEL) begin
            p_nx = p_up;
          end else if (state == ACCEL) begin
            p_nx = p_dn;
            if (p_dn < p)
              acc_nx = acc + CNT_W'(1);
            if (p_dn == pm_r)
              state_nx = CRUISE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        stop_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ph       <= '0;
      p        <= '0;
      ps_r     <= '0;
      pm_r     <= '0;
      dec_r    <= '0;
      rem      <= '0;
      acc      <= '0;
      cnt      <= '0;
      dir_r    <= 1'b0;
      stop_req <= 1'b0;
    end else begin
      state    <= state_nx;
      ph       <= ph_nx;
      p        <= p_nx;
      ps_r     <= ps_nx;
      pm_r     <= pm_nx;
      dec_r    <= dec_nx;
      rem      <= rem_nx;
      acc      <= acc_nx;
      cnt      <= cnt_nx;
      dir_r    <= dir_nx;
      stop_req <= stop_nx;
    end
  end

endmodule

// File: tb/tb_sm_ramp_ctrl.sv
// Bench for sm_ramp_ctrl: directed moves plus random moves against a
// step-by-step period model of the ramp rules.
module tb_sm_ramp_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #10 clk = ~clk;

  sm_ramp_ctrl_if bus ();

  sm_ramp_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  // Expected period of every step of a move, from the ramp rules.
  function automatic void model(input int tgt, input int ps, input int pm,
                                input int dec, input int stop_at);
    int p, rem, acc, nxt;
    bit up, down, stop;
    p    = ps;
    rem  = tgt;
    acc  = 0;
    up   = (ps > pm) && (dec != 0);
    down = 0;
    stop = 0;
    exp_q.delete();
    for (int s = 1; rem > 0 && s < 1000; s++) begin
      exp_q.push_back(p);
      if (s == stop_at) stop = 1;
      rem--;
      if (rem == 0) break;
      if (stop) begin
        stop = 0;
        if (acc < rem) rem = acc;
        if (rem == 0) break;
        down = 1;
        up   = 0;
        p    = (p + dec > ps) ? ps : p + dec;
      end else if (!down && rem <= acc) begin
        down = 1;
        up   = 0;
        p    = (p + dec > ps) ? ps : p + dec;
      end else if (down) begin
        p = (p + dec > ps) ? ps : p + dec;
      end else if (up) begin
        nxt = p - dec;
        if (nxt < pm) nxt = pm;
        if (nxt < p) acc++;
        p = nxt;
        if (p == pm) up = 0;
      end
    end
  endfunction

  task automatic scramble();
    bus.target_steps = $urandom;
    bus.dir_in       = 1'($urandom);
    bus.period_start = 16'($urandom);
    bus.period_min   = 16'($urandom);
    bus.ramp_dec     = 16'($urandom);
  endtask

  task automatic run_move(input string nm, input int tgt, input int ps_in,
                          input int pm_in, input int dec, input bit dir,
                          input int stop_at, input bit use_model,
                          input bit noise, input bit stop_w_start);
    int ps, pm, sum, nsteps, done_at, len, hi, cnt_at_done, bad;
    int per_q[$], hi_q[$], cp_q[$];
    bit prev, seen_done, dir_bad, gap_bad;
    pm = (pm_in > 4) ? pm_in : 4;
    ps = (ps_in > pm) ? ps_in : pm;
    if (use_model) model(tgt, ps, pm, dec, stop_at);
    sum = 0;
    foreach (exp_q[i]) sum += exp_q[i];
    @(posedge clk); #1;
    bus.cmd_start    = 1'b1;
    bus.cmd_stop     = stop_w_start;
    bus.target_steps = tgt;
    bus.dir_in       = dir;
    bus.period_start = 16'(ps_in);
    bus.period_min   = 16'(pm_in);
    bus.ramp_dec     = 16'(dec);
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    if (noise) scramble();
    prev = 0; nsteps = 0; len = 0; hi = 0;
    seen_done = 0; dir_bad = 0; gap_bad = 0;
    done_at = -1; cnt_at_done = -1;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (bus.cmd_stop) bus.cmd_stop = 1'b0;
      if (bus.done) begin
        seen_done   = 1;
        done_at     = c;
        cnt_at_done = int'(bus.step_cnt);
        break;
      end
      if (bus.busy) begin
        if (bus.drv_step && !prev) begin
          if (nsteps > 0) begin
            per_q.push_back(len);
            hi_q.push_back(hi);
          end
          nsteps++;
          len = 0;
          hi  = 0;
          cp_q.push_back(int'(bus.cur_period));
          if (nsteps == stop_at) bus.cmd_stop = 1'b1;
        end
        len++;
        if (bus.drv_step) hi++;
        if (bus.drv_dir !== dir || bus.drv_enable_SM !== 1'b1) dir_bad = 1;
      end else begin
        gap_bad = 1;
      end
      prev = bus.drv_step;
      if (noise) begin
        scramble();
        bus.cmd_start = ($urandom_range(0, 3) == 0);
      end
    end
    bus.cmd_start = 1'b0;
    if (nsteps > 0) begin
      per_q.push_back(len);
      hi_q.push_back(hi);
    end

    n_tests++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL %s done_timeout: no done pulse within budget", nm);
    end
    n_tests++;
    if (done_at != sum + 1) begin
      n_fail++;
      $display("FAIL %s done_time: got cycle %0d expected %0d", nm, done_at, sum + 1);
    end
    n_tests++;
    if (nsteps != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s nsteps: got %0d expected %0d", nm, nsteps, exp_q.size());
    end
    n_tests++;
    bad = -1;
    foreach (exp_q[i])
      if (bad < 0 && (i >= per_q.size() || per_q[i] != exp_q[i] ||
                      hi_q[i] != (exp_q[i] >> 2) || cp_q[i] != exp_q[i]))
        bad = i;
    if (bad >= 0) begin
      n_fail++;
      if (bad >= per_q.size())
        $display("FAIL %s period[%0d]: step missing, expected period %0d",
                 nm, bad, exp_q[bad]);
      else
        $display("FAIL %s period[%0d]: got len %0d high %0d cur %0d expected %0d/%0d",
                 nm, bad, per_q[bad], hi_q[bad], cp_q[bad], exp_q[bad], exp_q[bad] >> 2);
    end
    n_tests++;
    if (cnt_at_done != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s step_cnt: got %0d expected %0d", nm, cnt_at_done, exp_q.size());
    end
    n_tests++;
    if (dir_bad || gap_bad) begin
      n_fail++;
      $display("FAIL %s busy_outputs: got dir/enable error %0b gap %0b expected 0 0",
               nm, dir_bad, gap_bad);
    end
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.drv_step !== 1'b0 ||
        int'(bus.step_cnt) != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s after_done: got busy %b done %b step %b cnt %0d expected 0 0 0 %0d",
               nm, bus.busy, bus.done, bus.drv_step, bus.step_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.drv_step !== 1'b0 ||
        bus.drv_enable_SM !== 1'b0 || bus.drv_dir !== 1'b0 ||
        bus.step_cnt !== '0 || bus.cur_period !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy %b done %b step %b en %b dir %b cnt %0d per %0d expected all 0",
               bus.busy, bus.done, bus.drv_step, bus.drv_enable_SM,
               bus.drv_dir, bus.step_cnt, bus.cur_period);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.drv_step !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy %b done %b step %b expected 0 0 0",
               bus.busy, bus.done, bus.drv_step);
    end
  endtask

  task automatic test_flat();
    exp_q = '{8, 8, 8};
    run_move("flat", 3, 8, 8, 0, 1'b1, 0, 0, 0, 0);
  endtask

  task automatic test_trapezoid();
    exp_q = '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20};
    run_move("trapezoid", 10, 20, 8, 4, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_triangle();
    exp_q = '{20, 16, 12, 16};
    run_move("triangle", 4, 20, 8, 4, 1'b1, 0, 0, 0, 0);
  endtask

  task automatic test_stop();
    exp_q = '{20, 16, 12, 8, 8, 12, 16, 20};
    run_move("stop", 10, 20, 8, 4, 1'b1, 5, 0, 0, 0);
  endtask

  task automatic test_zero();
    exp_q.delete();
    run_move("zero", 0, 20, 8, 4, 1'b1, 0, 0, 0, 0);
  endtask

  task automatic test_clamp();
    exp_q = '{4, 4, 4};
    run_move("clamp", 3, 3, 2, 1, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_busy_start();
    exp_q = '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20};
    run_move("busy_start", 10, 20, 8, 4, 1'b1, 0, 0, 1, 0);
  endtask

  task automatic test_start_stop_idle();
    exp_q = '{20, 16, 12, 16};
    run_move("start_stop_idle", 4, 20, 8, 4, 1'b0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(posedge clk); #1;
    bus.cmd_start    = 1'b1;
    bus.target_steps = 20;
    bus.dir_in       = 1'b1;
    bus.period_start = 16'd8;
    bus.period_min   = 16'd8;
    bus.ramp_dec     = 16'd0;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    repeat (37) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.drv_step !== 1'b0 ||
        bus.drv_enable_SM !== 1'b0 || bus.drv_dir !== 1'b0 ||
        bus.step_cnt !== '0 || bus.cur_period !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got busy %b done %b step %b en %b dir %b cnt %0d per %0d expected all 0",
               bus.busy, bus.done, bus.drv_step, bus.drv_enable_SM,
               bus.drv_dir, bus.step_cnt, bus.cur_period);
    end
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got done/busy after abort expected none");
    end
    exp_q = '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20};
    run_move("after_reset", 10, 20, 8, 4, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int tgt, ps, pm, dec, stp;
    for (int k = 0; k < 30; k++) begin
      tgt = $urandom_range(0, 12);
      pm  = $urandom_range(0, 12);
      ps  = $urandom_range(0, 24);
      dec = $urandom_range(0, 6);
      stp = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, tgt + 1);
      run_move($sformatf("rand%0d", k), tgt, ps, pm, dec, 1'($urandom),
               stp, 1, 1, 1'($urandom));
    end
  endtask

  initial begin
    bus.cmd_start    = 1'b0;
    bus.cmd_stop     = 1'b0;
    bus.target_steps = '0;
    bus.dir_in       = 1'b0;
    bus.period_start = '0;
    bus.period_min   = '0;
    bus.ramp_dec     = '0;
    test_reset();
    test_flat();
    test_trapezoid();
    test_triangle();
    test_stop();
    test_zero();
    test_clamp();
    test_busy_start();
    test_start_stop_idle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
